// File: rtl/feature_flatten_buffer_if.sv
// feature_flatten_buffer_if
// Groups the capture-side inputs, the streaming handshake and the status
// flags of feature_flatten_buffer. The design uses the slave view and
// whatever drives it (controller/dense engine or a bench) uses the master view.
interface feature_flatten_buffer_if #(
  parameter int NUM_CH = 8,
  parameter int DW     = 8,
  parameter int IDX_W  = 10
);
  // capture side
  logic                   start;
  logic                   in_valid;
  logic [NUM_CH*DW-1:0]   in_data;
  logic                   in_done;
  // stream side
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_idx;
  logic                   out_last;
  // status
  logic                   busy;
  logic                   done;
  logic                   short_err;
  logic                   ovf_err;

  modport master (
    output start, in_valid, in_data, in_done, out_ready,
    input  out_data, out_valid, out_idx, out_last,
    input  busy, done, short_err, ovf_err
  );

  modport slave (
    input  start, in_valid, in_data, in_done, out_ready,
    output out_data, out_valid, out_idx, out_last,
    output busy, done, short_err, ovf_err
  );
endinterface

// File: rtl/feature_flatten_buffer.sv
// feature_flatten_buffer
// Captures NUM_POS pooled vectors of NUM_CH bytes from the layer-2 pooling
// controller and streams them as one flat feature vector, one byte per
// valid/ready handshake, to the dense-layer engine.
// Optional build macro FLATTEN_CH_MAJOR_EN selects channel-major flatten
// order (index c*NUM_POS+pos); without it the order is position-major
// (index pos*NUM_CH+c).
//
// Storage is NUM_CH banks, one per channel, each NUM_POS deep, so a whole
// pooled vector is written in one cycle at address pos_cnt. Both flatten
// orders then reduce to walking a (pos, ch) read pointer in a different
// nesting order, which avoids any divide-by-NUM_POS on the read path.
module feature_flatten_buffer #(
  parameter int NUM_CH  = 8,
  parameter int NUM_POS = 100,
  parameter int DW      = 8,
  parameter int IDX_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  feature_flatten_buffer_if.slave  bus
);

  localparam int TOTAL = NUM_CH * NUM_POS;
  localparam int PW    = $clog2(NUM_POS + 1);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;

  logic [PW-1:0]          pos_cnt_reg;
  logic [PW-1:0]          pos_inc;
  logic [IDX_W-1:0]       rd_idx_reg;
  logic [PW-1:0]          rd_pos_reg;
  logic [PW-1:0]          rd_pos_next;
  logic [PW-1:0]          rd_pos_adv;
  logic [CW-1:0]          rd_ch_reg;
  logic [CW-1:0]          rd_ch_next;
  logic [CW-1:0]          rd_ch_adv;
  logic                   short_err_reg;
  logic                   ovf_err_reg;

  logic                   wr_en;
  logic                   fill_full;
  logic                   fill_end;
  logic                   short_hit;
  logic                   hs;
  logic                   rd_is_last;
  logic                   pad;
  logic [NUM_CH*DW-1:0]   bank_q_flat;
  logic [DW-1:0]          rd_byte;

  // ---------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------
  assign wr_en     = (state_reg == FILL) && bus.in_valid;
  assign pos_inc   = pos_cnt_reg + PW'(1);
  // capture of the final position ends the fill on the same edge
  assign fill_full = wr_en && (pos_inc == PW'(NUM_POS));
  // in_done is judged after any capture in the same cycle
  assign fill_end  = fill_full || ((state_reg == FILL) && bus.in_done);
  assign short_hit = (state_reg == FILL) && bus.in_done && !fill_full;
  assign hs        = (state_reg == DRAIN) && bus.out_ready;
  // one extra bit so the compare cannot alias after rd_idx advances
  assign rd_is_last = ({1'b0, rd_idx_reg} == (IDX_W+1)'(TOTAL - 1));
  // positions at or beyond the captured count read as zero; in position-major
  // order this is the same as rd_idx >= pos_cnt*NUM_CH
  assign pad       = (rd_pos_reg >= pos_cnt_reg);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = FILL;
      FILL:    if (fill_end) state_next = DRAIN;
      DRAIN:   if (hs && rd_is_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // outputs; everything is forced low outside DRAIN so reset clears it at once
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.busy      = (state_reg != IDLE);
    bus.done      = (state_reg == FIN);
    if (state_reg == DRAIN) begin
      bus.out_valid = 1'b1;
      bus.out_idx   = rd_idx_reg;
      bus.out_last  = rd_is_last;
      bus.out_data  = pad ? '0 : rd_byte;
    end
  end

  assign bus.short_err = short_err_reg;
  assign bus.ovf_err   = ovf_err_reg;

  // ---------------------------------------------------------------------
  // Capture counter and sticky errors
  // ---------------------------------------------------------------------

  // pos_cnt counts captured vectors of the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start) begin
      pos_cnt_reg <= '0;
    end else if (wr_en) begin
      pos_cnt_reg <= pos_inc;
    end
  end

  // sticky error flags; a stray in_valid on the start cycle still reports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      short_err_reg <= 1'b0;
      ovf_err_reg   <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && bus.start) begin
        short_err_reg <= 1'b0;
        ovf_err_reg   <= 1'b0;
      end
      if (short_hit) begin
        short_err_reg <= 1'b1;
      end
      if (bus.in_valid && (state_reg != FILL)) begin
        ovf_err_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pointer: flat index plus its (pos, ch) decomposition
  // ---------------------------------------------------------------------

  // advance (pos, ch) in the flatten order of this build
  always_comb begin
    rd_pos_adv = rd_pos_reg;
    rd_ch_adv  = rd_ch_reg;
`ifdef FLATTEN_CH_MAJOR_EN
    if (rd_pos_reg == PW'(NUM_POS - 1)) begin
      rd_pos_adv = '0;
      rd_ch_adv  = rd_ch_reg + CW'(1);
    end else begin
      rd_pos_adv = rd_pos_reg + PW'(1);
    end
`else
    if (rd_ch_reg == CW'(NUM_CH - 1)) begin
      rd_ch_adv  = '0;
      rd_pos_adv = rd_pos_reg + PW'(1);
    end else begin
      rd_ch_adv  = rd_ch_reg + CW'(1);
    end
`endif
  end

  // pointer for the next cycle; held on a stall so the RAM output stays put
  always_comb begin
    rd_pos_next = rd_pos_reg;
    rd_ch_next  = rd_ch_reg;
    if ((state_reg == FIN) || (hs && rd_is_last)) begin
      rd_pos_next = '0;
      rd_ch_next  = '0;
    end else if (hs) begin
      rd_pos_next = rd_pos_adv;
      rd_ch_next  = rd_ch_adv;
    end
  end

  // read pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pos_reg <= '0;
      rd_ch_reg  <= '0;
    end else begin
      rd_pos_reg <= rd_pos_next;
      rd_ch_reg  <= rd_ch_next;
    end
  end

  // flat read index reported on out_idx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_reg <= '0;
    end else if (state_reg == FIN) begin
      rd_idx_reg <= '0;
    end else if (hs) begin
      rd_idx_reg <= rd_idx_reg + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel storage banks (not reset; contents survive rst)
  // ---------------------------------------------------------------------
  // The registered read is addressed by rd_pos_next, so the byte for the
  // current rd_pos is already in q_reg when DRAIN begins and stays there
  // while the consumer stalls.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_bank
      logic [DW-1:0] mem [NUM_POS];
      logic [DW-1:0] q_reg;

      // one byte of every captured vector lands in this channel's bank
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[pos_cnt_reg] <= bus.in_data[gi*DW +: DW];
        end
      end

      // registered read at the upcoming read position
      always_ff @(posedge clk) begin
        q_reg <= mem[rd_pos_next];
      end

      assign bank_q_flat[gi*DW +: DW] = q_reg;
    end
  endgenerate

  assign rd_byte = bank_q_flat[rd_ch_reg*DW +: DW];

endmodule

// File: tb/tb_feature_flatten_buffer.sv
// tb_feature_flatten_buffer
// Directed frame sequence with random data and random handshake timing,
// checked against a flat reference built from the captured vectors.
// Define FLATTEN_CH_MAJOR_EN for the channel-major build.
module tb_feature_flatten_buffer;

  localparam int NUM_CH  = 8;
  localparam int NUM_POS = 100;
  localparam int DW      = 8;
  localparam int IDX_W   = 10;
  localparam int TOTAL   = NUM_CH * NUM_POS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  feature_flatten_buffer_if #(.NUM_CH(NUM_CH), .DW(DW), .IDX_W(IDX_W)) bus ();

  feature_flatten_buffer #(
    .NUM_CH(NUM_CH), .NUM_POS(NUM_POS), .DW(DW), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // reference: captured vectors of the current frame
  int cap [NUM_POS][NUM_CH];
  int n_cap = 0;

  // expected flat word k from the captured vectors
  function automatic int exp_word(int k);
    int p;
    int c;
`ifdef FLATTEN_CH_MAJOR_EN
    c = k / NUM_POS;
    p = k % NUM_POS;
`else
    p = k / NUM_CH;
    c = k % NUM_CH;
`endif
    return (p < n_cap) ? cap[p][c] : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start a frame and feed n captures; short frames end with in_done,
  // either on the last capture cycle or on a separate cycle
  task automatic fill_frame(input int n, input bit rnd, input bit done_with_last);
    logic [NUM_CH*DW-1:0] v;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
    check("short_err_cleared", 32'(bus.short_err), 0);
    check("ovf_err_cleared", 32'(bus.ovf_err), 0);
    n_cap = n;
    for (int p = 0; p < n; p++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("no_valid_in_fill", 32'(bus.out_valid), 0);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        cap[p][c] = rnd ? int'($urandom_range(0, 255)) : ((p + c) & 255);
        v[c*DW +: DW] = 8'(cap[p][c]);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      bus.in_done  = done_with_last && (p == n - 1);
      @(negedge clk);
      if (p == 0) check("no_valid_in_fill", 32'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    if (n < NUM_POS && !done_with_last) begin
      bus.in_done = 1'b1;
      @(negedge clk);
      bus.in_done = 1'b0;
    end
    check("first_valid_latency", 32'(bus.out_valid), 1);
    check("first_idx", 32'(bus.out_idx), 0);
    check("short_err_flag", 32'(bus.short_err), (n < NUM_POS) ? 1 : 0);
  endtask

  // stream the frame; mode 0 ready=1, 1 ready pattern 1,0,0,1, 2 random
  // ready plus stray start pulses; optional in_valid pulse at word ovf_at;
  // stop_at>=0 returns at that word without finishing
  task automatic drain(input int mode, input int ovf_at, input int stop_at);
    int k = 0;
    int cyc = 0;
    bit r;
    bit ovf_fired = 1'b0;
    while (k < TOTAL && cyc < 5000) begin
      if (stop_at >= 0 && k == stop_at) break;
      check("out_valid", 32'(bus.out_valid), 1);
      check("out_idx", 32'(bus.out_idx), k);
      check("out_data", 32'(bus.out_data), exp_word(k));
      check("out_last", 32'(bus.out_last), (k == TOTAL - 1) ? 1 : 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.start = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (k == ovf_at && !ovf_fired) begin
        bus.in_valid = 1'b1;
        bus.in_data  = {NUM_CH{8'hA5}};
        ovf_fired    = 1'b1;
      end
      bus.out_ready = r;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      cyc++;
      if (r) k++;
    end
    bus.out_ready = 1'b0;
    if (stop_at >= 0 && k == stop_at) return;
    if (k < TOTAL) begin
      check("drain_timeout", k, TOTAL);
      return;
    end
    check("done_pulse", 32'(bus.done), 1);
    check("valid_after_last", 32'(bus.out_valid), 0);
    if (ovf_at >= 0) check("ovf_err_set", 32'(bus.ovf_err), 1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    check("idle_after_fin", 32'(bus.busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_data"}, 32'(bus.out_data), 0);
    check({tag, "_idx"}, 32'(bus.out_idx), 0);
    check({tag, "_last"}, 32'(bus.out_last), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_short"}, 32'(bus.short_err), 0);
    check({tag, "_ovf"}, 32'(bus.ovf_err), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_done   = 1'b0;
    bus.out_ready = 1'b0;

    // power-on reset
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // full frame with p+c data, no backpressure
    fill_frame(NUM_POS, 1'b0, 1'b0);
    drain(0, -1, -1);
    $display("frame A: full p+c, ready=1");

    // full random frame with 1,0,0,1 backpressure
    fill_frame(NUM_POS, 1'b1, 1'b0);
    drain(1, -1, -1);
    $display("frame B: full random, ready 1,0,0,1");

    // short frame of 60 captures, separate in_done
    fill_frame(60, 1'b0, 1'b0);
    drain(0, -1, -1);
    $display("frame C: short 60, zero padded");

    // short random frame with in_done on the last capture
    fill_frame(37, 1'b1, 1'b1);
    drain(2, -1, -1);
    $display("frame D: short 37, in_done with last capture");

    // overflow pulse during DRAIN
    fill_frame(NUM_POS, 1'b1, 1'b0);
    drain(2, 200, -1);
    $display("frame E: in_valid during drain");

    // next start clears ovf_err; reset at word 300
    fill_frame(NUM_POS, 1'b1, 1'b0);
    drain(0, -1, 300);
    rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    $display("frame F: reset at word 300");

    // full frame after the mid-stream reset
    fill_frame(NUM_POS, 1'b1, 1'b0);
    drain(0, -1, -1);
    $display("frame G: full random after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
